// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          DEFAULT_DEPTH = 2;
  localparam logic [31:0] INSTR_BYTES   = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer of DEPTH {pc, instr} entries (DEPTH a power
// of two). Flush wins over push/pop; push when full and pop when empty are
// ignored.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; head outputs are masked by the parent while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with one outstanding memory
// request and a small instruction buffer. Redirects flush the buffer; a
// response already in flight at a redirect is discarded in DROP.
// Define FETCH_ALIGN_CHECK_EN to add fault_o and block fetch after a
// misaligned redirect until the next aligned one.
import fetch_pkg::*;

module fetch_unit #(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fault_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d, go_st;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          push, pop;
  logic [CW-1:0] count, occ_after;
  fetch_entry_t  head, wentry;
  logic          fault_blk, fault_nxt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic bad_redir;

  assign bad_redir = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  assign fault_d   = redirect_i ? bad_redir : fault_q;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault_blk = fault_q;
  assign fault_nxt = fault_d;
  assign fault_o   = fault_q;
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc_i[1:0];
  assign fault_blk    = 1'b0;
  assign fault_nxt    = 1'b0;
`endif

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = fetch_pc_q;

  // A redirect flushes the buffer, so it also suppresses the pop.
  assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;
  assign occ_after = count + CW'(1) - CW'(pop);
  assign wentry    = '{pc: fetch_pc_q - INSTR_BYTES, instr: mem_rdata_i};
  // Where to go once no response is pending after a redirect.
  assign go_st     = fault_nxt ? IDLE : REQ;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (count)
  );

  // Fetch FSM next state; redirect overrides the normal flow and any push.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      IDLE: if (!fault_blk && (count < CW'(DEPTH) || pop)) state_d = REQ;
      REQ: if (mem_gnt_i) begin
        fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        state_d    = RESP;
      end
      RESP: if (mem_rvalid_i) begin
        push    = 1'b1;
        state_d = (occ_after < CW'(DEPTH)) ? REQ : IDLE;
      end
      DROP: if (mem_rvalid_i) state_d = fault_blk ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_i) begin
      push       = 1'b0;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      case (state_q)
        IDLE:    state_d = go_st;
        REQ:     state_d = mem_gnt_i ? DROP : go_st;
        RESP:    state_d = mem_rvalid_i ? go_st : DROP;
        DROP:    state_d = mem_rvalid_i ? go_st : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and fetch address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized phase. A memory
// responder with programmable grant/response delays feeds the DUT; a
// stream model (expected next consumed pc, expected next filled pc,
// occupancy) checks every cycle.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk, reset;
  logic        redirect_i, instr_ready_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_valid_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_o;
`endif

  int checks = 0;
  int failures = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
`ifdef FETCH_ALIGN_CHECK_EN
    .fault_o       (fault_o),
`endif
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          gnt_dly = 0, rv_dly = 0, cur_g = 0;
  bit          rand_mode = 1'b0;
  bit          outst = 1'b0;
  int          rwait = 0, gwait = 0;
  logic [31:0] out_addr = '0, rv_addr = '0;

  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        outst = 1'b0; gwait = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      end else begin
        mem_rvalid_i = 1'b0;
        if (outst) begin
          chk("one_outstanding", 32'(mem_req_o), 32'd0);
          if (rwait == 0) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = memfn(out_addr);
            rv_addr = out_addr; outst = 1'b0;
          end else rwait--;
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
          if (gwait >= (rand_mode ? cur_g : gnt_dly)) begin
            mem_gnt_i = 1'b1; gwait = 0; outst = 1'b1; out_addr = mem_addr_o;
            rwait = rand_mode ? 32'($urandom_range(0, 3)) : rv_dly;
            cur_g = 32'($urandom_range(0, 3));
          end else gwait++;
        end else gwait = 0;
      end
    end
  end

  // ---------------- stream model / monitor ----------------
  int          occ = 0, pops = 0;
  logic [31:0] exp_pop = '0, exp_fill = '0, prev_addr = '0;
  bit          prev_pend = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      occ = 0; exp_pop = '0; exp_fill = '0; prev_pend = 1'b0;
    end else begin
      chk("valid_vs_model", 32'(instr_valid_o), 32'(occ != 0));
      if (mem_req_o) chk("req_has_space", 32'(occ < DEPTH), 32'd1);
      if (prev_pend && mem_req_o) chk("addr_stable", mem_addr_o, prev_addr);
      prev_pend = mem_req_o && !mem_gnt_i && !redirect_i;
      prev_addr = mem_addr_o;
      if (redirect_i) begin
        occ = 0;
        exp_pop  = {redirect_pc_i[31:2], 2'b00};
        exp_fill = exp_pop;
      end else begin
        if (instr_valid_o && instr_ready_i) begin
          chk("pop_pc", instr_pc_o, exp_pop);
          chk("pop_instr", instr_o, memfn(exp_pop));
          exp_pop += 32'd4; pops++;
          if (occ > 0) occ--;
        end
        if (mem_rvalid_i && rv_addr == exp_fill) begin
          occ++; exp_fill += 32'd4;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", 32'(fault_o), 32'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_i = 1'b1; redirect_pc_i = a;
    cyc();
    redirect_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid_o && n < 200) begin cyc(); n++; end
    chk(tag, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    int p0;
    logic [31:0] k;
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;

    // A: zero-wait, ready=1: 0,4,8 at cycles 3,5,7 after release
    instr_ready_i = 1'b1;
    do_reset();
    cyc(); chk("a_req0", 32'(mem_req_o), 32'd1); chk("a_addr0", mem_addr_o, 32'h0);
    cyc(); chk("a_valid_c2", 32'(instr_valid_o), 32'd0);
    cyc(); chk("a_valid_c3", 32'(instr_valid_o), 32'd1); chk("a_pc0", instr_pc_o, 32'h0);
    chk("a_addr4", mem_addr_o, 32'h4);
    cyc(); cyc(); chk("a_pc4", instr_pc_o, 32'h4); chk("a_addr8", mem_addr_o, 32'h8);
    cyc(); cyc(); chk("a_pc8", instr_pc_o, 32'h8);

    // B: ready=0 fills two entries, then one pop restarts fetch at 8
    instr_ready_i = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("b_full_req", 32'(mem_req_o), 32'd0); chk("b_head", instr_pc_o, 32'h0);
    cyc(); chk("b_full_req2", 32'(mem_req_o), 32'd0);
    cyc(); chk("b_full_req3", 32'(mem_req_o), 32'd0);
    instr_ready_i = 1'b1;
    cyc(); instr_ready_i = 1'b0;
    chk("b_req8", 32'(mem_req_o), 32'd1); chk("b_addr8", mem_addr_o, 32'h8);
    chk("b_head4", instr_pc_o, 32'h4);
    repeat (3) cyc();
    chk("b_idle", 32'(mem_req_o), 32'd0);
    redir(32'h1000);
    chk("b_flush", 32'(instr_valid_o), 32'd0); chk("b_raddr", mem_addr_o, 32'h1000);
    cyc(); cyc();
    chk("b_lat3", 32'(instr_valid_o), 32'd1); chk("b_rpc", instr_pc_o, 32'h1000);

    // C: redirect while waiting on the response for address 8
    rv_dly = 2; instr_ready_i = 1'b1;
    do_reset();
    n = 0;
    while (!(mem_gnt_i && mem_addr_o == 32'h8) && n < 100) begin cyc(); n++; end
    chk("c_gnt8_seen", 32'(mem_gnt_i && mem_addr_o == 32'h8), 32'd1);
    cyc(); instr_ready_i = 1'b0;
    redir(32'h100);
    wait_valid("c_valid_seen");
    chk("c_pc100", instr_pc_o, 32'h100); chk("c_instr100", instr_o, memfn(32'h100));
    repeat (12) cyc();
    chk("c_head_kept", instr_pc_o, 32'h100);
    instr_ready_i = 1'b1; cyc(); instr_ready_i = 1'b0;
    chk("c_next104", instr_pc_o, 32'h104);

    // D: redirect + pop + rvalid in one cycle
    rv_dly = 0; instr_ready_i = 1'b0;
    do_reset();
    n = 0;
    while (!(mem_rvalid_i && instr_valid_o) && n < 100) begin cyc(); n++; end
    chk("d_coincide_seen", 32'(mem_rvalid_i && instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    redir(32'h300);
    chk("d_empty", 32'(instr_valid_o), 32'd0);
    cyc(); cyc();
    chk("d_lat3", 32'(instr_valid_o), 32'd1); chk("d_pc300", instr_pc_o, 32'h300);
    repeat (20) cyc();

    // E: grant after 5 cycles, rvalid 3 cycles after that
    gnt_dly = 5; rv_dly = 3;
    redir(32'h400);
    p0 = pops;
    wait_valid("e_valid_seen");
    chk("e_pc400", instr_pc_o, 32'h400);
    repeat (100) cyc();
    chk("e_progress", 32'(pops - p0 >= 5), 32'd1);

    // F: randomized delays, backpressure and redirects
    rand_mode = 1'b1; k = '0; p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0010_0000 + k * 32'h1_0000 + (32'($urandom_range(0, 63)) << 2);
        k = k + 32'd1;
      end else redirect_i = 1'b0;
      cyc();
    end
    redirect_i = 1'b0;
    chk("f_progress", 32'(pops - p0 >= 100), 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    // G: misaligned redirect faults and blocks until an aligned redirect
    rand_mode = 1'b0; gnt_dly = 0; rv_dly = 0; instr_ready_i = 1'b1;
    repeat (4) cyc();
    redir(32'h102);
    chk("g_fault_set", 32'(fault_o), 32'd1);
    chk("g_flush", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(); chk("g_no_req", 32'(mem_req_o), 32'd0);
    end
    chk("g_fault_held", 32'(fault_o), 32'd1);
    redir(32'h200);
    chk("g_fault_clr", 32'(fault_o), 32'd0);
    chk("g_addr200", mem_addr_o, 32'h200);
    wait_valid("g_valid_seen");
    chk("g_pc200", instr_pc_o, 32'h200);
`endif

    repeat (5) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2: number of instruction buffer entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- redirect_i  in  1  PC is non-sequential (taken branch or jump).
- redirect_pc_i  in  32  new fetch address.
- instr_o  out  32  instruction at buffer head.
- instr_pc_o  out  32  address of instr_o.
- instr_valid_o  out  1  buffer head valid.
- instr_ready_i  in  1  core consumes the head.
- mem_req_o  out  1  fetch request to instruction memory.
- mem_addr_o  out  32  word-aligned request address.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response data valid.
- mem_rdata_i  in  32  response word.
- fault_o  out  1  misaligned redirect, present only with FETCH_ALIGN_CHECK_EN.

Function
REQ-004 Memory protocol SHALL be: at most one outstanding request; mem_rvalid_i arrives one or more cycles after mem_gnt_i; a request not yet granted may be withdrawn or its address changed.
REQ-005 FSM states SHALL be IDLE, REQ, RESP and DROP.
REQ-006 mem_req_o SHALL be 1 only in REQ, and mem_addr_o SHALL equal fetch_pc.
REQ-007 IDLE->REQ SHALL occur when occupancy < DEPTH and no fault is pending.
REQ-008 In REQ, on mem_gnt_i: fetch_pc <= fetch_pc + 4 (wraps modulo 2^32), and the FSM goes to RESP.
REQ-009 In RESP, on mem_rvalid_i: {fetch_pc-4, mem_rdata_i} SHALL be pushed, and the FSM goes to REQ if occupancy after push < DEPTH, else IDLE.
REQ-010 A request SHALL never be issued when the response would have no free slot; the buffer SHALL never overflow.
REQ-011 instr_valid_o SHALL be 1 iff occupancy > 0, with instr_o and instr_pc_o driven from the head entry.
REQ-012 A pop SHALL occur on instr_valid_o & instr_ready_i; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-013 On redirect_i, all buffer entries SHALL be flushed, with instr_valid_o 0 in the next cycle, and fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
REQ-014 Redirect in RESP, or in REQ with mem_gnt_i the same cycle, SHALL go to DROP.
- DROP discards the next mem_rvalid_i, then goes to REQ.
- A redirect during DROP updates fetch_pc only.
REQ-015 Redirect in REQ without grant, or in IDLE, SHALL go to REQ with the new address next cycle.
REQ-016 Redirect SHALL take priority over a same-cycle pop and over a same-cycle mem_rvalid_i push; that response is dropped.
REQ-017 With zero-wait memory (grant in request cycle, rvalid the next cycle), redirect to instr_valid_o SHALL be 3 cycles and sustained throughput SHALL be 1 instruction per 2 cycles.

Reset
REQ-018 Reset SHALL force the following state:
- FSM IDLE, fetch_pc = RESET_PC, buffer empty.
- mem_req_o = 0, instr_valid_o = 0, fault_o = 0.
- instr_o = 0 and instr_pc_o = 0.
REQ-019 Reset asserted mid-transaction SHALL abandon the outstanding request; the memory is reset by the same signal.
REQ-020 The first mem_req_o SHALL assert in the second clock edge's cycle after reset deassertion (IDLE->REQ).

Configuration
REQ-021 With FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc_i[1:0] != 0 SHALL:
- set fault_o (held);
- flush the buffer;
- block new requests until the next aligned redirect, which clears fault_o.
REQ-022 Without FETCH_ALIGN_CHECK_EN, the fault_o port SHALL be absent and redirect_pc_i[1:0] SHALL be ignored.

Structure
REQ-023 Package fetch_pkg SHALL hold the FSM state enum, the fetch_entry_t struct {pc, instr}, and the constants DEFAULT_DEPTH and INSTR_BYTES = 4.
REQ-024 Buffering SHALL be a sub-module fetch_fifo with parameterized depth, push, pop, flush, count and registered storage; fetch_unit holds the FSM and fetch_pc.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, zero-wait memory, ready=1: addresses 0,4,8 requested; instr_pc_o sequence 0,4,8; first instr_valid_o 3 cycles after reset release.
- ready=0, DEPTH=2: after 2 pushes mem_req_o stays 0; one pop -> request for address 8 next cycle.
- Redirect to 0x100 while in RESP: the stale response (addr 8) is dropped; next instr_pc_o = 0x100; no extra push.
- Redirect, pop and rvalid in the same cycle: buffer empty next cycle; only redirect target entries appear afterwards.
- Grant delayed 5 cycles and rvalid delayed 3 cycles: mem_addr_o stable while req=1; order and data intact.
- FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fault_o=1, no requests; redirect to 0x200 -> fault_o=0, fetch resumes at 0x200.
